// File: rtl/lfsr10_checker.sv
// lfsr10_checker
//   Receive-side checker for a 10-bit XNOR LFSR (taps 10 and 7, shift left,
//   feedback into bit 0). It locks onto the incoming word stream, predicts each
//   next word, and counts mispredictions while locked.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a new generator word this cycle
//   in_data    generator word, bit 9 = q10 ... bit 0 = q1
//   clear_err  synchronous clear of err_count
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse per mispredicted word while locked
//   err_count  saturating count of mispredicted words
//   stuck      last valid word was the lock-up word 10'h3FF
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | building a run of LOCK_COUNT consecutive correct successors
// LOCKED | predicting every word; LOSS_COUNT consecutive misses drop lock

module lfsr10_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [9:0]       in_data,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  localparam int MCW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int LCW = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
  localparam logic [9:0] LOCKUP = 10'h3FF;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [9:0]       ref_word;
  logic             have_ref;
  logic [MCW-1:0]   match_cnt;
  logic [LCW-1:0]   miss_cnt;

  logic [9:0]       succ_ref;
  logic             is_match;
  logic             err_event;

  function automatic logic [9:0] succ(input logic [9:0] w);
    return {w[8:0], ~(w[9] ^ w[6])};
  endfunction

  // The lock-up word is its own successor, so it must never count as a
  // match; otherwise a stuck generator would look healthy.
  always_comb begin
    succ_ref  = succ(ref_word);
    is_match  = (in_data == succ_ref) && (in_data != LOCKUP);
    err_event = in_valid && (state == LOCKED) && !is_match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      ref_word  <= '0;
      have_ref  <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      stuck     <= 1'b0;
    end else begin
      err_pulse <= err_event;

      // A clear coinciding with an error leaves that error counted.
      if (clear_err)
        err_count <= err_event ? ERR_W'(1) : '0;
      else if (err_event && (err_count != {ERR_W{1'b1}}))
        err_count <= err_count + 1'b1;

      if (in_valid) begin
        stuck <= (in_data == LOCKUP);

        case (state)
          HUNT: begin
            ref_word <= in_data;
            if (!have_ref) begin
              have_ref  <= 1'b1;
              match_cnt <= '0;
            end else if (is_match) begin
              if (match_cnt == MCW'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          LOCKED: begin
            if (is_match) begin
              ref_word <= in_data;
              miss_cnt <= '0;
            end else if (miss_cnt == LCW'(LOSS_COUNT - 1)) begin
              // Lock lost: this word becomes the new hunting reference.
              state     <= HUNT;
              locked    <= 1'b0;
              ref_word  <= in_data;
              have_ref  <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              // Flywheel the prediction rather than resyncing on bad data.
              ref_word <= succ_ref;
              miss_cnt <= miss_cnt + 1'b1;
            end
          end

          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr10_checker.sv
module tb_lfsr10_checker;

  logic        clk;
  logic        rst_n;
  logic        in_valid, clear_err;
  logic [9:0]  in_data;
  logic        locked, err_pulse, stuck;
  logic [15:0] err_count;

  logic        b_valid, b_clear;
  logic [9:0]  b_data;
  logic        b_locked, b_err_pulse, b_stuck;
  logic [3:0]  b_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr10_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .stuck(stuck)
  );

  lfsr10_checker #(.LOCK_COUNT(4), .LOSS_COUNT(32), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
    .clear_err(b_clear), .locked(b_locked), .err_pulse(b_err_pulse),
    .err_count(b_err_count), .stuck(b_stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of input, let the DUT sample it, return at the next
  // falling edge where the registered outputs reflect that word.
  task automatic step(input logic v, input logic [9:0] d, input logic clr);
    in_valid  = v;
    in_data   = d;
    clear_err = clr;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic b_step(input logic v, input logic [9:0] d);
    b_valid = v;
    b_data  = d;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_locked"}, {31'b0, locked}, 32'd0);
    check({tag, "_pulse"},  {31'b0, err_pulse}, 32'd0);
    check({tag, "_count"},  {16'b0, err_count}, 32'd0);
    check({tag, "_stuck"},  {31'b0, stuck}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; clear_err = 1'b0;
    b_valid = 1'b0;  b_data = '0;  b_clear = 1'b0;

    // Reset held with inputs toggling
    repeat (6) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      in_data   = 10'($urandom);
      clear_err = 1'($urandom);
      b_valid   = 1'($urandom);
      b_data    = 10'($urandom);
    end
    @(negedge clk);
    check_idle("rst_hold");
    check("rst_hold_b_locked", {31'b0, b_locked}, 32'd0);
    in_valid = 1'b0; clear_err = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    repeat (5) step(1'b0, 10'h000, 1'b0);
    check_idle("rst_idle");

    // Lock acquisition
    step(1'b1, 10'h000, 1'b0);
    step(1'b1, 10'h001, 1'b0);
    step(1'b1, 10'h003, 1'b0);
    step(1'b1, 10'h007, 1'b0);
    check("acq_after_007", {31'b0, locked}, 32'd0);
    step(1'b1, 10'h00F, 1'b0);
    check("acq_after_00f", {31'b0, locked}, 32'd1);
    check("acq_no_err", {16'b0, err_count}, 32'd0);

    // Single error with flywheel
    step(1'b1, 10'h01F, 1'b0);
    check("fw_01f_pulse", {31'b0, err_pulse}, 32'd0);
    step(1'b1, 10'h155, 1'b0);
    check("fw_bad_pulse", {31'b0, err_pulse}, 32'd1);
    check("fw_bad_count", {16'b0, err_count}, 32'd1);
    check("fw_bad_locked", {31'b0, locked}, 32'd1);
    step(1'b1, 10'h07F, 1'b0);
    check("fw_07f_pulse", {31'b0, err_pulse}, 32'd0);
    step(1'b1, 10'h0FE, 1'b0);
    check("fw_0fe_pulse", {31'b0, err_pulse}, 32'd0);
    check("fw_0fe_count", {16'b0, err_count}, 32'd1);
    check("fw_0fe_locked", {31'b0, locked}, 32'd1);

    // Clear, then loss of lock
    step(1'b0, 10'h000, 1'b1);
    check("clr_count", {16'b0, err_count}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 10'h200, 1'b0);
      check($sformatf("loss%0d_pulse", i), {31'b0, err_pulse}, 32'd1);
      check($sformatf("loss%0d_count", i), {16'b0, err_count}, 32'(i));
      check($sformatf("loss%0d_locked", i), {31'b0, locked}, (i < 3) ? 32'd1 : 32'd0);
    end
    step(1'b0, 10'h000, 1'b0);
    check("loss_pulse_end", {31'b0, err_pulse}, 32'd0);

    // Relock from reference 200: successors 000, 001, 003, 007
    step(1'b1, 10'h000, 1'b0);
    step(1'b1, 10'h001, 1'b0);
    step(1'b1, 10'h003, 1'b0);
    check("relock_3", {31'b0, locked}, 32'd0);
    step(1'b1, 10'h007, 1'b0);
    check("relock_4", {31'b0, locked}, 32'd1);

    // Clear coinciding with a miss
    step(1'b1, 10'h200, 1'b1);
    check("clrmiss_count", {16'b0, err_count}, 32'd1);
    check("clrmiss_pulse", {31'b0, err_pulse}, 32'd1);

    // Asynchronous reset mid-lock, checked before any rising edge
    #1 rst_n = 1'b0;
    #1;
    check("async_locked", {31'b0, locked}, 32'd0);
    check("async_count", {16'b0, err_count}, 32'd0);
    check("async_pulse", {31'b0, err_pulse}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock-up word
    repeat (10) step(1'b1, 10'h3FF, 1'b0);
    check("lockup_stuck", {31'b0, stuck}, 32'd1);
    check("lockup_locked", {31'b0, locked}, 32'd0);
    check("lockup_count", {16'b0, err_count}, 32'd0);
    step(1'b1, 10'h001, 1'b0);
    check("lockup_release", {31'b0, stuck}, 32'd0);
    step(1'b0, 10'h3FF, 1'b0);
    check("stuck_hold", {31'b0, stuck}, 32'd0);

    // Lock with idle gaps, reference now 001
    step(1'b1, 10'h003, 1'b0);
    step(1'b0, 10'h000, 1'b0);
    step(1'b1, 10'h007, 1'b0);
    step(1'b0, 10'h155, 1'b0);
    step(1'b1, 10'h00F, 1'b0);
    check("gap_3", {31'b0, locked}, 32'd0);
    step(1'b0, 10'h200, 1'b0);
    step(1'b1, 10'h01F, 1'b0);
    check("gap_4", {31'b0, locked}, 32'd1);
    check("gap_count", {16'b0, err_count}, 32'd0);

    // Saturation on the narrow-counter instance
    b_step(1'b1, 10'h000);
    b_step(1'b1, 10'h001);
    b_step(1'b1, 10'h003);
    b_step(1'b1, 10'h007);
    b_step(1'b1, 10'h00F);
    check("sat_locked", {31'b0, b_locked}, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      b_step(1'b1, 10'h3FF);
      if (i == 3)  check("sat_3", {28'b0, b_err_count}, 32'd3);
      if (i == 15) check("sat_15", {28'b0, b_err_count}, 32'hF);
    end
    check("sat_20", {28'b0, b_err_count}, 32'hF);
    check("sat_20_locked", {31'b0, b_locked}, 32'd1);
    check("sat_20_pulse", {31'b0, b_err_pulse}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
